fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of decode and immediate sign-extension.
- Holds the PC and issues one request at a time to instruction memory, which has variable latency and a req/ack handshake.
- Presents each returned instruction with its PC and PC+4 in a one-entry valid/ready output slot.
- Decode slices id_instr[31:7] for the immediate extender.
- Branch/jump redirects from downstream flush the slot and discard any in-flight response.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  ADDR_WIDTH  request address; stable while imem_req high and unacked.
- imem_ack  in  1  response valid; may arrive in any cycle imem_req is high, including the first.
- imem_rdata  in  DATA_WIDTH  instruction, valid when imem_ack.
- redirect_valid  in  1  one-cycle redirect/flush strobe.
- redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] ignored and forced to 0.
- id_valid  out  1  output slot holds an instruction.
- id_ready  in  1  decode accepts the slot this cycle.
- id_instr  out  DATA_WIDTH  fetched instruction.
- id_pc  out  ADDR_WIDTH  address of id_instr.
- id_pc_plus4  out  ADDR_WIDTH  id_pc + 4, modulo 2^ADDR_WIDTH.

Behaviour:
- Registers: state, fetch_pc (drives imem_addr), pend_pc (redirect target captured during DROP), output slot.
- Reset (rst_n low, asynchronous): state=REQ, fetch_pc=RESET_PC, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0, id_pc_plus4=0.
- imem_req is 0 while rst_n is low and 1 in the first cycle after release.
- State REQ: imem_req=1, imem_addr=fetch_pc. The slot is always empty in REQ; this is an invariant.
  - On imem_ack with no redirect: load the slot (id_valid=1, id_instr=imem_rdata, id_pc=fetch_pc, id_pc_plus4=fetch_pc+4); fetch_pc<=fetch_pc+4; go to IDLE.
  - Request-to-slot latency is 1 cycle after the ack edge.
- State IDLE: imem_req=0.
  - If id_valid && id_ready: the slot clears (id_valid=0) and the state goes to REQ.
  - Peak throughput is one instruction per 2 cycles when memory acks in the same cycle as the request.
- State DROP: imem_req=1, imem_addr=fetch_pc (old address held).
  - On imem_ack: data discarded, fetch_pc<=pend_pc, go to REQ.
- Redirect has priority over every other event:
  - In IDLE: slot flushed (id_valid<=0), fetch_pc<=redirect_pc, go to REQ. A simultaneous id_ready handshake still counts as completed.
  - In REQ with no ack: pend_pc<=redirect_pc, go to DROP. The request is not withdrawn.
  - In REQ with ack in the same cycle: response discarded, slot stays empty, fetch_pc<=redirect_pc, stay in REQ.
  - In DROP with no ack: pend_pc overwritten; the last redirect wins.
  - In DROP with ack in the same cycle: response discarded, fetch_pc<=redirect_pc, go to REQ.
- The slot outputs hold stable while id_valid && !id_ready.
- PC wraps modulo 2^ADDR_WIDTH; 32'hFFFF_FFFC + 4 = 0.
- Reset asserted mid-request abandons the request immediately. Memory must tolerate req dropping on reset.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output ports perf_fetch_cnt[31:0] and perf_drop_cnt[31:0], both reset to 0 and wrapping.
  - perf_fetch_cnt increments on each id_valid && id_ready handshake.
  - perf_drop_cnt increments on each discarded imem_ack, whether in DROP or redirect-with-ack.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {REQ, IDLE, DROP}.
  - INSTR_NOP = 32'h0000_0013.
  - PC_STEP = 4.
- One sub-module, fetch_out_slot: the valid/ready output register, with load, flush and drain inputs. Everything else stays in fetch_unit.

Test Plan:
- Reset release; memory acks 0x00500093 in the same cycle as the request; id_ready=1 -> cycle 1: id_valid=1, id_instr=0x00500093, id_pc=0, id_pc_plus4=4. Next request at addr 4 two cycles after the first.
- id_ready=0 for 5 cycles with the slot full -> imem_req stays 0 and outputs are stable. id_ready=1 -> request for the next PC in the following cycle.
- Memory latency 3 cycles, redirect to 0x100 in the first wait cycle -> imem_addr holds the old PC until ack, response dropped, next request at 0x100, no id_valid for the dropped word.
- Redirect to 0x203 during IDLE with id_ready=1 -> slot flushed, next imem_addr=0x200.
- Two redirects (0x40 then 0x80) during DROP -> next fetch at 0x80.
- With FETCH_PERF_EN: 10 delivered instructions and 2 drops -> perf_fetch_cnt=10, perf_drop_cnt=2. Assert rst_n low mid-request -> imem_req=0 immediately and counters=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    IDLE = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

endpackage

// File: rtl/fetch_out_slot.sv
// One-entry valid/ready output register carrying the instruction, its PC and PC+4.
module fetch_out_slot
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  flush,
  input  logic                  drain,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      instr    <= DATA_WIDTH'(INSTR_NOP);
      pc       <= '0;
      pc_plus4 <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= instr_in;
      pc       <= pc_in;
      pc_plus4 <= pc_in + ADDR_WIDTH'(PC_STEP);
    end else if (flush || drain) begin
      // data is left in place; only the valid flag matters once emptied
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, redirect/flush handling.
// Optional FETCH_PERF_EN adds delivered-instruction and dropped-response counters.
//
// state | meaning
// REQ   | request outstanding at fetch_pc, output slot empty
// IDLE  | slot full, waiting for decode to take it
// DROP  | stale request still outstanding; its response is discarded, then fetch pend_pc
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [ADDR_WIDTH-1:0] id_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_drop_cnt
`endif
);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] pend_pc;
  logic [ADDR_WIDTH-1:0] redir_pc;
  logic                  slot_load;
  logic                  slot_flush;
  logic                  handshake;

  assign redir_pc   = redirect_pc & ~ADDR_WIDTH'(3);
  assign handshake  = id_valid && id_ready;
  assign slot_load  = (state == REQ) && imem_ack && !redirect_valid;
  assign slot_flush = (state == IDLE) && redirect_valid;

  // req must fall the instant reset asserts, so it is gated by rst_n directly
  assign imem_req  = rst_n && (state != IDLE);
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      pend_pc  <= RESET_PC;
    end else begin
      case (state)
        REQ: begin
          if (redirect_valid) begin
            if (imem_ack) begin
              fetch_pc <= redir_pc;
            end else begin
              pend_pc <= redir_pc;
              state   <= DROP;
            end
          end else if (imem_ack) begin
            fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_STEP);
            state    <= IDLE;
          end
        end
        IDLE: begin
          if (redirect_valid) begin
            fetch_pc <= redir_pc;
            state    <= REQ;
          end else if (handshake) begin
            state <= REQ;
          end
        end
        DROP: begin
          if (imem_ack) begin
            fetch_pc <= redirect_valid ? redir_pc : pend_pc;
            state    <= REQ;
          end else if (redirect_valid) begin
            pend_pc <= redir_pc;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

  fetch_out_slot #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (slot_load),
    .flush    (slot_flush),
    .drain    (handshake),
    .instr_in (imem_rdata),
    .pc_in    (fetch_pc),
    .valid    (id_valid),
    .instr    (id_instr),
    .pc       (id_pc),
    .pc_plus4 (id_pc_plus4)
  );

`ifdef FETCH_PERF_EN
  logic drop_evt;
  assign drop_evt = imem_ack && ((state == DROP) || ((state == REQ) && redirect_valid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (handshake) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (drop_evt)  perf_drop_cnt  <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable memory model and an output scoreboard.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   lat   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.pc4   = pc4;
    q.push_back(e);
  endtask

  // inputs are driven and outputs checked 2ns after the falling edge
  task automatic tick;
    @(negedge clk);
    #2;
  endtask

  // memory: acks after 'lat' wait cycles of a continuously raised request
  initial begin
    int cnt;
    cnt        = 0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (imem_req) begin
        if (cnt >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = (imem_addr == 32'h0) ? 32'h0050_0093 : {imem_addr[19:0], 12'h013};
          cnt        = 0;
        end else begin
          imem_ack = 1'b0;
          cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        cnt      = 0;
      end
    end
  end

  // monitor: every completed handshake must match the next expected word
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && id_valid && id_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected actual_pc=%h required=none", id_pc);
        end else begin
          e = q.pop_front();
          chk("sb_instr", id_instr, e.instr);
          chk("sb_pc", id_pc, e.pc);
          chk("sb_pc4", id_pc_plus4, e.pc4);
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'h0000_0013);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pc4", id_pc_plus4, 32'h0);

    // first fetch, memory acks in the request cycle
    @(negedge clk);
    push(32'h0050_0093, 32'h0, 32'h4);
    rst_n = 1'b1;
    #2;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    tick;
    chk("first_valid", {31'd0, id_valid}, 32'd1);
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    tick;
    chk("second_req", {31'd0, imem_req}, 32'd1);
    chk("second_addr", imem_addr, 32'h4);
    push(32'h0000_4013, 32'h4, 32'h8);
    id_ready = 1'b0;

    // back-pressure: slot full, no request, outputs frozen
    repeat (5) begin
      tick;
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_valid", {31'd0, id_valid}, 32'd1);
      chk("stall_instr", id_instr, 32'h0000_4013);
      chk("stall_pc", id_pc, 32'h4);
    end
    id_ready = 1'b1;
    lat      = 3;

    // redirect during a slow request: old address held, response dropped
    tick;
    chk("next_req", {31'd0, imem_req}, 32'd1);
    chk("next_addr", imem_addr, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick;
    redirect_valid = 1'b0;
    chk("drop_req", {31'd0, imem_req}, 32'd1);
    chk("drop_addr0", imem_addr, 32'h8);
    tick;
    chk("drop_addr1", imem_addr, 32'h8);
    tick;
    chk("drop_addr2", imem_addr, 32'h8);
    chk("drop_novalid", {31'd0, id_valid}, 32'd0);
    lat = 0;
    push(32'h0010_0013, 32'h100, 32'h104);
    tick;
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_novalid", {31'd0, id_valid}, 32'd0);
    tick;
    chk("redir_valid", {31'd0, id_valid}, 32'd1);

    // redirect in IDLE with a simultaneous handshake, unaligned target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick;
    redirect_valid = 1'b0;
    chk("flush_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_req", {31'd0, imem_req}, 32'd1);
    chk("flush_addr", imem_addr, 32'h200);
    push(32'h0020_0013, 32'h200, 32'h204);
    tick;
    chk("flush_load", {31'd0, id_valid}, 32'd1);
    lat = 4;

    // two redirects while dropping: last one wins
    tick;
    chk("dd_addr", imem_addr, 32'h204);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick;
    redirect_pc = 32'h80;
    tick;
    redirect_valid = 1'b0;
    chk("dd_hold0", imem_addr, 32'h204);
    tick;
    chk("dd_hold1", imem_addr, 32'h204);
    tick;
    chk("dd_hold2", imem_addr, 32'h204);
    lat = 0;
    push(32'h0008_0013, 32'h80, 32'h84);
    tick;
    chk("dd_target", imem_addr, 32'h80);
    chk("dd_req", {31'd0, imem_req}, 32'd1);
    tick;
    chk("dd_valid", {31'd0, id_valid}, 32'd1);

    // redirect coincident with ack in REQ: response discarded, stay in REQ
    tick;
    chk("ra_addr", imem_addr, 32'h84);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick;
    redirect_valid = 1'b0;
    chk("ra_novalid", {31'd0, id_valid}, 32'd0);
    chk("ra_req", {31'd0, imem_req}, 32'd1);
    chk("ra_addr2", imem_addr, 32'h300);
    push(32'h0030_0013, 32'h300, 32'h304);
    tick;
    chk("ra_valid", {31'd0, id_valid}, 32'd1);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick;
    redirect_valid = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    push(32'hFFFF_C013, 32'hFFFF_FFFC, 32'h0);
    tick;
    chk("wrap_valid", {31'd0, id_valid}, 32'd1);
    chk("wrap_pc4", id_pc_plus4, 32'h0);
    push(32'h0050_0093, 32'h0, 32'h4);
    tick;
    chk("wrap_next", imem_addr, 32'h0);
    tick;
    chk("wrap_load", {31'd0, id_valid}, 32'd1);
    lat = 5;
    tick;
    chk("mid_req", {31'd0, imem_req}, 32'd1);
    chk("mid_addr", imem_addr, 32'h4);
`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, 32'd8);
    chk("perf_drop", perf_drop_cnt, 32'd3);
`endif

    // reset mid-request abandons it at once
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, imem_req}, 32'd0);
    chk("rst_mid_valid", {31'd0, id_valid}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("rst_perf_drop", perf_drop_cnt, 32'd0);
`endif
    chk("sb_left", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=done");
    $fatal(1);
  end

endmodule
